// File: rtl/fp_mul_if.sv
// Operand/result bundle for the floating-point multiplier.
// Ports: flp_a/flp_b packed operands {sign, exp, frac}; sign/exponent/prod result fields.
// master drives operands and reads results; slave is the multiplier side.
interface fp_mul_if #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
);
  localparam int W = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH;

  logic [W-1:0]              flp_a;
  logic [W-1:0]              flp_b;
  logic                      sign;
  logic [EXPONENT_WIDTH-1:0] exponent;
  logic [MANTISSA_WIDTH-1:0] prod;

  modport master (output flp_a, flp_b, input sign, exponent, prod);
  modport slave  (input flp_a, flp_b, output sign, exponent, prod);
endinterface

// File: rtl/fp_mul.sv
// IEEE-754-style multiplier (RNE, flush-to-zero, quiet-NaN), result as separate fields.
// Latency 1 cycle, throughput 1 operand pair per cycle.
// No backpressure: operands are taken every cycle and outputs hold until the next edge.
// Ports: clk, rst (sync, active high); mul_io.slave carries flp_a/flp_b in and
// sign/exponent/prod out.
module fp_mul #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic   clk,
  input  logic   rst,
  fp_mul_if.slave mul_io
);
  localparam int E = EXPONENT_WIDTH;
  localparam int M = MANTISSA_WIDTH;
  localparam int W = 1 + E + M;

  // Exponent math runs on E+2 bits and is read as two's complement so that
  // both underflow (negative) and overflow (> 2^E-1) remain visible.
  localparam logic [E+1:0] BIAS_X  = {3'b000, {(E-1){1'b1}}};
  localparam logic [E+1:0] EXP_MAX = {2'b00, {E{1'b1}}};
  localparam logic [M-1:0] QNAN    = {1'b1, {(M-1){1'b0}}};

  logic [W-1:0] a, b;
  logic         a_s, b_s;
  logic [E-1:0] ea, eb;
  logic [M-1:0] fa, fb;
  logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a   = mul_io.flp_a;
  assign b   = mul_io.flp_b;
  assign a_s = a[W-1];
  assign b_s = b[W-1];
  assign ea  = a[W-2:M];
  assign eb  = b[W-2:M];
  assign fa  = a[M-1:0];
  assign fb  = b[M-1:0];

  // A zero exponent counts as zero whatever the fraction: denormals are flushed.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  // Significand product, 1.x * 1.x lands in [1, 4).
  logic [2*M+1:0] prod_full;
  logic           norm_hi;
  logic [2*M:0]   norm;
  logic [M-1:0]   mant;
  logic           guard, sticky, round_up;
  logic [M:0]     mant_r;
  logic [E+1:0]   exp_f;
  logic           ovf, unf;

  assign prod_full = {{(M+1){1'b0}}, 1'b1, fa} * {{(M+1){1'b0}}, 1'b1, fb};
  assign norm_hi   = prod_full[2*M+1];
  // Align so the hidden bit sits just above norm's MSB in both cases.
  assign norm      = norm_hi ? prod_full[2*M:0] : {prod_full[2*M-1:0], 1'b0};
  assign mant      = norm[2*M:M+1];
  assign guard     = norm[M];
  assign sticky    = |norm[M-1:0];
  assign round_up  = guard & (sticky | mant[0]);
  // A carry out of the rounded fraction means 1.11..1 became 10.00..0; the
  // fraction bits are already all zero, so only the exponent needs bumping.
  assign mant_r    = {1'b0, mant} + {{M{1'b0}}, round_up};
  assign exp_f     = {2'b00, ea} + {2'b00, eb} - BIAS_X
                   + {{(E+1){1'b0}}, norm_hi} + {{(E+1){1'b0}}, mant_r[M]};
  assign ovf       = !exp_f[E+1] && (exp_f >= EXP_MAX);
  assign unf       = exp_f[E+1] || (exp_f == '0);

  logic         sign_d, sign_q;
  logic [E-1:0] exponent_d, exponent_q;
  logic [M-1:0] prod_d, prod_q;

  always_comb begin
    sign_d     = a_s ^ b_s;
    exponent_d = '0;
    prod_d     = '0;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      exponent_d = '1;
      prod_d     = QNAN;
    end else if (a_inf || b_inf || ovf) begin
      exponent_d = '1;
    end else if (a_zero || b_zero || unf) begin
      exponent_d = '0;
    end else begin
      exponent_d = exp_f[E-1:0];
      prod_d     = mant_r[M-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q     <= 1'b0;
      exponent_q <= '0;
      prod_q     <= '0;
    end else begin
      sign_q     <= sign_d;
      exponent_q <= exponent_d;
      prod_q     <= prod_d;
    end
  end

  assign mul_io.sign     = sign_q;
  assign mul_io.exponent = exponent_q;
  assign mul_io.prod     = prod_q;
endmodule

// File: tb/tb_fp_mul.sv
// Bench for fp_mul: directed vectors, special cases, rounding, random stream with reset.
module tb_fp_mul;
  localparam int E = 8;
  localparam int M = 23;

  typedef struct packed {
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_mul_if #(.EXPONENT_WIDTH(E), .MANTISSA_WIDTH(M)) bus ();
  fp_mul #(.EXPONENT_WIDTH(E), .MANTISSA_WIDTH(M)) dut (
    .clk    (clk),
    .rst    (rst),
    .mul_io (bus)
  );

  res_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference: exact product in double precision (24x24 bits fits in 53),
  // then rounded to single with round-to-nearest-even. Inputs kept in range.
  function automatic res_t ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [10:0] ead, ebd, ep;
    logic [63:0] pd;
    logic [23:0] m;
    real         ra, rb;
    res_t        r;
    ead = {3'b000, a[30:23]} + 11'd896;
    ebd = {3'b000, b[30:23]} + 11'd896;
    ra  = $bitstoreal({1'b0, ead, a[22:0], 29'd0});
    rb  = $bitstoreal({1'b0, ebd, b[22:0], 29'd0});
    pd  = $realtobits(ra * rb);
    m   = {1'b0, pd[51:29]} + {23'd0, pd[28] & ((|pd[27:0]) | pd[29])};
    ep  = pd[62:52] - 11'd896 + {10'd0, m[23]};
    r.s = a[31] ^ b[31];
    r.e = ep[7:0];
    r.f = m[22:0];
    return r;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input res_t r, input string nm);
    @(negedge clk);
    bus.flp_a = a;
    bus.flp_b = b;
    exp_q.push_back(r);
    name_q.push_back(nm);
  endtask

  task automatic test_reset();
    res_t got;
    rst = 1'b1;
    bus.flp_a = 32'h40A00000;
    bus.flp_b = 32'h40400000;
    repeat (2) @(posedge clk);
    #1;
    got = {bus.sign, bus.exponent, bus.prod};
    checks++;
    if (got !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got %h required %h", got, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed vectors with hand-derived expectations.
  task automatic test_directed();
    logic [31:0] va[10] = '{32'h40A00000, 32'hC0A00000, 32'h40200000, 32'hC2C60000, 32'h3F000000,
                           32'h3F800001, 32'h3F800003, 32'h3FA1E58F, 32'h40000000, 32'hBF800000};
    logic [31:0] vb[10] = '{32'h40400000, 32'h40A00000, 32'h41200000, 32'hC2040000, 32'h3F000000,
                           32'h3FC00000, 32'h3FC00000, 32'h3FCA6691, 32'h40000000, 32'h3F800000};
    logic [31:0] ve[10] = '{{1'b0, 8'h82, 23'h700000}, {1'b1, 8'h83, 23'h480000},
                           {1'b0, 8'h83, 23'h480000}, {1'b0, 8'h8A, 23'h4C3000},
                           {1'b0, 8'h7D, 23'h000000}, {1'b0, 8'h7F, 23'h400002},
                           {1'b0, 8'h7F, 23'h400004}, {1'b0, 8'h80, 23'h000000},
                           {1'b0, 8'h81, 23'h000000}, {1'b1, 8'h7F, 23'h000000}};
    res_t got, want;
    string nm;
    for (int i = 0; i < 10; i++) begin
      drive(va[i], vb[i], ve[i], $sformatf("directed_%0d", i));
      @(posedge clk);
      #1;
      got = {bus.sign, bus.exponent, bus.prod};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL directed_queue: got empty scoreboard required entry");
      end else begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL %s: got s=%b e=%h f=%h required s=%b e=%h f=%h",
                   nm, got.s, got.e, got.f, want.s, want.e, want.f);
        end
      end
    end
  endtask

  // Zero, infinity, NaN, overflow and underflow handling.
  task automatic test_special();
    logic [31:0] va[9] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h7F000000, 32'h00800000,
                          32'hFF800000, 32'h7FC00001, 32'h00000001, 32'h80000000};
    logic [31:0] vb[9] = '{32'h41400000, 32'h00000000, 32'h00000000, 32'h7F000000, 32'h00800000,
                          32'h40000000, 32'h3F800000, 32'h7F000000, 32'h41400000};
    logic [31:0] ve[9] = '{32'h00000000, 32'h00000000, {1'b0, 8'hFF, 23'h400000},
                          {1'b0, 8'hFF, 23'h0}, 32'h00000000, {1'b1, 8'hFF, 23'h0},
                          {1'b0, 8'hFF, 23'h400000}, 32'h00000000, 32'h80000000};
    res_t got, want;
    string nm;
    for (int i = 0; i < 9; i++) begin
      drive(va[i], vb[i], ve[i], $sformatf("special_%0d", i));
      @(posedge clk);
      #1;
      got = {bus.sign, bus.exponent, bus.prod};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL special_queue: got empty scoreboard required entry");
      end else begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL %s: got s=%b e=%h f=%h required s=%b e=%h f=%h",
                   nm, got.s, got.e, got.f, want.s, want.e, want.f);
        end
      end
    end
  endtask

  // One pair per cycle; a one-cycle reset in the middle must zero the outputs.
  task automatic test_back_to_back();
    logic [31:0] a, b;
    res_t got, want;
    string nm;
    for (int i = 0; i < 21; i++) begin
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(80, 170)), 23'($urandom)};
      b = {1'($urandom_range(0, 1)), 8'($urandom_range(80, 170)), 23'($urandom)};
      if (i == 10) begin
        @(negedge clk);
        rst       = 1'b1;
        bus.flp_a = a;
        bus.flp_b = b;
        exp_q.push_back('0);
        name_q.push_back("stream_reset");
      end else begin
        drive(a, b, ref_mul(a, b), $sformatf("stream_%0d", i));
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      got = {bus.sign, bus.exponent, bus.prod};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL stream_queue: got empty scoreboard required entry");
      end else begin
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL %s: a=%h b=%h got s=%b e=%h f=%h required s=%b e=%h f=%h",
                   nm, a, b, got.s, got.e, got.f, want.s, want.e, want.f);
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.flp_a = '0;
    bus.flp_b = '0;
    test_reset();
    test_directed();
    test_special();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
